// File: rtl/lsu_pkg.sv
// Shared definitions for the data-memory load/store unit.
// Provides the memory op encoding, the exception codes, the FSM state type,
// and small helpers that classify ops by direction and access size.
package lsu_pkg;

    typedef enum logic [3:0] {
        OP_LB  = 4'd0,
        OP_LBU = 4'd1,
        OP_LH  = 4'd2,
        OP_LHU = 4'd3,
        OP_LW  = 4'd4,
        OP_SB  = 4'd5,
        OP_SH  = 4'd6,
        OP_SW  = 4'd7
    } op_e;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_e;

    function automatic logic op_is_load(logic [3:0] op);
        return op <= 4'd4;
    endfunction

    function automatic logic op_is_store(logic [3:0] op);
        return (op >= 4'd5) && (op <= 4'd7);
    endfunction

    // Access size in bytes; 0 for illegal ops.
    function automatic logic [2:0] op_size(logic [3:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 3'd1;
            OP_LH, OP_LHU, OP_SH: return 3'd2;
            OP_LW, OP_SW:         return 3'd4;
            default:              return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Bundle of the LSU's request/response handshake and data-memory bus.
//   slave  : the LSU's view (takes requests, drives responses and memory)
//   master : the environment's view (execute stage + data memory)
interface dmem_lsu_if;

    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_exc;
    logic [4:0]  resp_exc_code;
    logic [31:0] resp_badvaddr;

    logic        dm_ena;
    logic        dm_wena;
    logic        dm_rena;
    logic [3:0]  dm_wflag;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, dm_rdata,
        output req_ready, resp_valid, resp_rdata, resp_exc, resp_exc_code,
               resp_badvaddr, dm_ena, dm_wena, dm_rena, dm_wflag, dm_addr,
               dm_wdata
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, dm_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_exc, resp_exc_code,
               resp_badvaddr, dm_ena, dm_wena, dm_rena, dm_wflag, dm_addr,
               dm_wdata
    );

endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the LSU (purely combinational).
//   op_i     : memory op        a_i    : byte offset within the word
//   rt_i     : store source     rdata_i: word read from data memory
//   wflag_o  : byte write enables for stores (0 for loads/illegal ops)
//   wdata_o  : store data replicated across lanes
//   load_o   : selected lane, sign/zero-extended for loads
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [1:0]  a_i,
    input  logic [31:0] rt_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wflag_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (a_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = a_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        wflag_o = '0;
        wdata_o = rt_i;
        load_o  = '0;
        case (op_i)
            OP_SB: begin
                wflag_o = 4'b0001 << a_i;
                wdata_o = {4{rt_i[7:0]}};
            end
            OP_SH: begin
                wflag_o = a_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{rt_i[15:0]}};
            end
            OP_SW:   wflag_o = 4'b1111;
            OP_LB:   load_o  = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_o  = {24'd0, byte_sel};
            OP_LH:   load_o  = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_o  = {16'd0, half_sel};
            OP_LW:   load_o  = rdata_i;
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit between execute and the byte-lane data memory.
// Accepts one request at a time (IDLE -> ACCESS -> RESP, or IDLE -> RESP on
// an exception), checks opcode, alignment and mapped range, drives the
// memory for one cycle and returns the extended load result or the fault.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request/response handshake and data-memory bus (slave view)
module dmem_lsu
    import lsu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    dmem_lsu_if.slave  bus
);

    state_e      state_q;
    logic [3:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        dm_ena_q, dm_wena_q, dm_rena_q;
    logic        resp_valid_q, resp_exc_q;
    logic [4:0]  exc_code_q;
    logic [31:0] rdata_q, badvaddr_q;

    // Classification of the incoming request, used only at the accept edge.
    logic        req_load, req_store, req_misal, req_oor, req_exc;
    logic [2:0]  req_size;
    logic [31:0] req_off;
    logic [32:0] req_end;
    logic [4:0]  req_code;

    always_comb begin
        req_load  = op_is_load(bus.req_op);
        req_store = op_is_store(bus.req_op);
        req_size  = op_size(bus.req_op);
        req_misal = ((req_size == 3'd2) && bus.req_addr[0]) ||
                    ((req_size == 3'd4) && (bus.req_addr[1:0] != 2'b00));
        // One past the last byte touched, widened so it cannot wrap.
        req_off   = bus.req_addr - BASE_ADDR;
        req_end   = {1'b0, req_off} + {30'd0, req_size};
        req_oor   = (bus.req_addr < BASE_ADDR) || (req_end > 33'(MEM_BYTES));
        req_exc   = !(req_load || req_store) || req_misal || req_oor;
        if (!(req_load || req_store)) begin
            req_code = EXC_RI;
        end else if (req_load) begin
            req_code = EXC_ADEL;
        end else begin
            req_code = EXC_ADES;
        end
    end

    logic [3:0]  lane_wflag;
    logic [31:0] lane_wdata, lane_load;

    lsu_lane_align u_align (
        .op_i    (op_q),
        .a_i     (addr_q[1:0]),
        .rt_i    (wdata_q),
        .rdata_i (bus.dm_rdata),
        .wflag_o (lane_wflag),
        .wdata_o (lane_wdata),
        .load_o  (lane_load)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            dm_ena_q     <= 1'b0;
            dm_wena_q    <= 1'b0;
            dm_rena_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_exc_q   <= 1'b0;
            exc_code_q   <= '0;
            rdata_q      <= '0;
            badvaddr_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        op_q    <= bus.req_op;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        if (req_exc) begin
                            resp_valid_q <= 1'b1;
                            resp_exc_q   <= 1'b1;
                            exc_code_q   <= req_code;
                            badvaddr_q   <= bus.req_addr;
                            rdata_q      <= '0;
                            state_q      <= ST_RESP;
                        end else begin
                            dm_ena_q  <= 1'b1;
                            dm_wena_q <= req_store;
                            dm_rena_q <= req_load;
                            state_q   <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    dm_ena_q     <= 1'b0;
                    dm_wena_q    <= 1'b0;
                    dm_rena_q    <= 1'b0;
                    resp_valid_q <= 1'b1;
                    resp_exc_q   <= 1'b0;
                    exc_code_q   <= '0;
                    badvaddr_q   <= '0;
                    rdata_q      <= dm_rena_q ? lane_load : '0;
                    state_q      <= ST_RESP;
                end
                ST_RESP: begin
                    resp_valid_q <= 1'b0;
                    resp_exc_q   <= 1'b0;
                    exc_code_q   <= '0;
                    badvaddr_q   <= '0;
                    rdata_q      <= '0;
                    state_q      <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready     = (state_q == ST_IDLE);
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_rdata    = rdata_q;
    assign bus.resp_exc      = resp_exc_q;
    assign bus.resp_exc_code = exc_code_q;
    assign bus.resp_badvaddr = badvaddr_q;
    assign bus.dm_ena        = dm_ena_q;
    assign bus.dm_wena       = dm_wena_q;
    assign bus.dm_rena       = dm_rena_q;
    // Write enable is only ever high in ACCESS, so lanes are quiet elsewhere.
    assign bus.dm_wflag      = dm_wena_q ? lane_wflag : '0;
    assign bus.dm_addr       = {addr_q[31:2], 2'b00};
    assign bus.dm_wdata      = lane_wdata;

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: byte-array reference model plus a
// word-wide data memory driven by the DUT's memory bus.
module tb_dmem_lsu;
    import lsu_pkg::*;

    localparam logic [31:0] BASE = 32'h1001_0000;
    localparam int unsigned MB   = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_lsu_if bus();

    dmem_lsu #(.BASE_ADDR(BASE), .MEM_BYTES(MB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Data memory seen by the DUT.
    logic [31:0] dmem [0:MB/4-1];
    logic [31:0] wr_word;
    assign bus.dm_rdata = dmem[bus.dm_addr[9:2]];
    always @(posedge clk) begin
        if (bus.dm_ena && bus.dm_wena) begin
            wr_word = dmem[bus.dm_addr[9:2]];
            for (int i = 0; i < 4; i++)
                if (bus.dm_wflag[i]) wr_word[8*i +: 8] = bus.dm_wdata[8*i +: 8];
            dmem[bus.dm_addr[9:2]] <= wr_word;
        end
    end

    // Reference byte memory, indexed by byte offset from BASE.
    logic [7:0] ref_mem [0:MB-1];

    // Behavioural model: classify, apply a store, or assemble a load.
    task automatic model(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rt,
                         output logic ex, output logic [4:0] code, output logic [31:0] bad,
                         output logic [31:0] rd, output logic [3:0] wflag);
        int unsigned size;
        longint unsigned a64;
        logic ld, st;
        logic [31:0] v;
        int unsigned off;
        ld = (op <= 4'd4);
        st = (op >= 4'd5) && (op <= 4'd7);
        size = (op == 4'd0 || op == 4'd1 || op == 4'd5) ? 1 :
               (op == 4'd2 || op == 4'd3 || op == 4'd6) ? 2 : 4;
        a64 = addr;
        ex = 1'b0; code = '0; bad = '0; rd = '0; wflag = '0;
        if (!ld && !st) begin
            ex = 1'b1; code = 5'd10; bad = addr;
        end else if ((addr % size) != 0) begin
            ex = 1'b1; code = ld ? 5'd4 : 5'd5; bad = addr;
        end else if (addr < BASE || (a64 - BASE + size) > MB) begin
            ex = 1'b1; code = ld ? 5'd4 : 5'd5; bad = addr;
        end else begin
            off = addr - BASE;
            if (st) begin
                for (int i = 0; i < int'(size); i++) begin
                    ref_mem[off + i] = rt[8*i +: 8];
                    wflag = wflag | (4'b0001 << ((addr + i) % 4));
                end
            end else begin
                v = '0;
                for (int i = 0; i < int'(size); i++) v[8*i +: 8] = ref_mem[off + i];
                if (op == 4'd0)      rd = {{24{v[7]}}, v[7:0]};
                else if (op == 4'd2) rd = {{16{v[15]}}, v[15:0]};
                else                 rd = v;
            end
        end
    endtask

    // Drive one request and observe the transaction up to its response.
    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd, output logic ex,
                         output logic [4:0] code, output logic [31:0] bad,
                         output logic saw_ena, output logic saw_wena, output logic saw_rena,
                         output logic [3:0] wflag, output logic [31:0] wdata);
        lat = 0; rd = '0; ex = 1'b0; code = '0; bad = '0;
        saw_ena = 1'b0; saw_wena = 1'b0; saw_rena = 1'b0; wflag = '0; wdata = '0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = addr; bus.req_wdata = wd;
        for (int i = 0; i < 8; i++) begin
            if (bus.req_ready) break;
            @(negedge clk);
        end
        @(posedge clk);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.req_valid = 1'b0;
                bus.req_op = 4'($urandom); bus.req_addr = $urandom; bus.req_wdata = $urandom;
            end
            if (bus.dm_ena) begin
                saw_ena = 1'b1;
                saw_wena = saw_wena | bus.dm_wena;
                saw_rena = saw_rena | bus.dm_rena;
                wflag = bus.dm_wflag;
                wdata = bus.dm_wdata;
            end
            if (bus.resp_valid) begin
                lat = c; rd = bus.resp_rdata; ex = bus.resp_exc;
                code = bus.resp_exc_code; bad = bus.resp_badvaddr;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        if ({bus.resp_valid, bus.resp_exc, bus.dm_ena, bus.dm_wena, bus.dm_rena} !== 5'b0) begin
            n_bad++; $display("FAIL reset_ctl: got %b want 00000",
                {bus.resp_valid, bus.resp_exc, bus.dm_ena, bus.dm_wena, bus.dm_rena});
        end
        n_cmp++;
        if ({bus.resp_rdata, bus.resp_badvaddr, bus.dm_addr, bus.dm_wflag, bus.resp_exc_code} !== '0) begin
            n_bad++; $display("FAIL reset_data: rdata %h bad %h addr %h wflag %b code %0d, want all 0",
                bus.resp_rdata, bus.resp_badvaddr, bus.dm_addr, bus.dm_wflag, bus.resp_exc_code);
        end
        n_cmp++;
        rst_n = 1'b1;
        @(negedge clk);
        if (bus.req_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_ready: got %b want 1", bus.req_ready);
        end
        n_cmp++;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [3:0]  wflag;
        logic [31:0] wdata;
    } sl_vec_t;

    sl_vec_t sl_vec [10] = '{
        '{OP_SW,  32'h1001_0004, 32'hDEAD_BEEF, 32'h0,         4'b1111, 32'hDEAD_BEEF},
        '{OP_LW,  32'h1001_0004, 32'h0,         32'hDEAD_BEEF, 4'b0000, 32'h0},
        '{OP_LB,  32'h1001_0007, 32'h0,         32'hFFFF_FFDE, 4'b0000, 32'h0},
        '{OP_LBU, 32'h1001_0007, 32'h0,         32'h0000_00DE, 4'b0000, 32'h0},
        '{OP_LH,  32'h1001_0006, 32'h0,         32'hFFFF_DEAD, 4'b0000, 32'h0},
        '{OP_LHU, 32'h1001_0004, 32'h0,         32'h0000_BEEF, 4'b0000, 32'h0},
        '{OP_SB,  32'h1001_0005, 32'h1234_5678, 32'h0,         4'b0010, 32'h7878_7878},
        '{OP_LW,  32'h1001_0004, 32'h0,         32'hDEAD_78EF, 4'b0000, 32'h0},
        '{OP_SH,  32'h1001_0006, 32'h0000_CAFE, 32'h0,         4'b1100, 32'hCAFE_CAFE},
        '{OP_LH,  32'h1001_0006, 32'h0,         32'hFFFF_CAFE, 4'b0000, 32'h0}
    };

    task automatic test_store_load();
        int lat; logic [31:0] rd, bad, wdata; logic ex, se, sw, sr; logic [4:0] code; logic [3:0] wf;
        logic mex; logic [4:0] mcode; logic [31:0] mbad, mrd; logic [3:0] mwf;
        for (int i = 0; i < 10; i++) begin
            issue(sl_vec[i].op, sl_vec[i].addr, sl_vec[i].wd, lat, rd, ex, code, bad, se, sw, sr, wf, wdata);
            model(sl_vec[i].op, sl_vec[i].addr, sl_vec[i].wd, mex, mcode, mbad, mrd, mwf);
            if (lat !== 2 || ex !== 1'b0) begin
                n_bad++; $display("FAIL sl_lat[%0d]: lat %0d exc %b want lat 2 exc 0", i, lat, ex);
            end
            n_cmp++;
            if (rd !== sl_vec[i].rd) begin
                n_bad++; $display("FAIL sl_rdata[%0d]: got %h want %h", i, rd, sl_vec[i].rd);
            end
            n_cmp++;
            if (op_is_store(sl_vec[i].op)) begin
                if ({se, sw, sr} !== 3'b110 || wf !== sl_vec[i].wflag) begin
                    n_bad++; $display("FAIL sl_store_en[%0d]: ena/wena/rena %b wflag %b want 110 %b",
                        i, {se, sw, sr}, wf, sl_vec[i].wflag);
                end
                n_cmp++;
                if (wdata !== sl_vec[i].wdata) begin
                    n_bad++; $display("FAIL sl_wdata[%0d]: got %h want %h", i, wdata, sl_vec[i].wdata);
                end
                n_cmp++;
            end else begin
                if ({se, sw, sr} !== 3'b101) begin
                    n_bad++; $display("FAIL sl_load_en[%0d]: ena/wena/rena %b want 101", i, {se, sw, sr});
                end
                n_cmp++;
            end
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [4:0]  code;
    } ex_vec_t;

    ex_vec_t ex_vec [8] = '{
        '{OP_LW,  32'h1001_0006, 5'd4},
        '{OP_SH,  32'h1001_0401, 5'd5},
        '{OP_SW,  32'h1001_0400, 5'd5},
        '{4'hF,   32'h1001_0004, 5'd10},
        '{OP_LB,  32'h1000_FFFF, 5'd4},
        '{OP_LHU, 32'h1001_03FF, 5'd4},
        '{OP_LH,  32'h1001_0400, 5'd4},
        '{4'h8,   32'h1001_0001, 5'd10}
    };

    task automatic test_exceptions();
        int lat; logic [31:0] rd, bad, wdata; logic ex, se, sw, sr; logic [4:0] code; logic [3:0] wf;
        for (int i = 0; i < 8; i++) begin
            issue(ex_vec[i].op, ex_vec[i].addr, $urandom, lat, rd, ex, code, bad, se, sw, sr, wf, wdata);
            if (lat !== 1 || ex !== 1'b1 || se !== 1'b0) begin
                n_bad++; $display("FAIL exc_flow[%0d]: lat %0d exc %b dm_ena %b want 1 1 0", i, lat, ex, se);
            end
            n_cmp++;
            if (code !== ex_vec[i].code || bad !== ex_vec[i].addr || rd !== 32'h0) begin
                n_bad++; $display("FAIL exc_info[%0d]: code %0d bad %h rdata %h want %0d %h 0",
                    i, code, bad, rd, ex_vec[i].code, ex_vec[i].addr);
            end
            n_cmp++;
        end
    endtask

    task automatic test_reset_in_access();
        int lat; logic [31:0] rd, bad, wdata; logic ex, se, sw, sr; logic [4:0] code; logic [3:0] wf;
        logic mex; logic [4:0] mcode; logic [31:0] mbad, mrd; logic [3:0] mwf;
        int pulses;
        issue(OP_SW, 32'h1001_0008, 32'hA5A5_5A5A, lat, rd, ex, code, bad, se, sw, sr, wf, wdata);
        model(OP_SW, 32'h1001_0008, 32'hA5A5_5A5A, mex, mcode, mbad, mrd, mwf);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = OP_SW; bus.req_addr = 32'h1001_0008; bus.req_wdata = 32'h1111_1111;
        @(posedge clk);
        #2;
        bus.req_valid = 1'b0;
        if (bus.dm_ena !== 1'b1) begin
            n_bad++; $display("FAIL rst_acc_pre: dm_ena %b want 1", bus.dm_ena);
        end
        n_cmp++;
        rst_n = 1'b0;
        #1;
        if ({bus.dm_ena, bus.dm_wena, bus.dm_wflag, bus.resp_valid} !== 7'b0) begin
            n_bad++; $display("FAIL rst_acc_drop: ena %b wena %b wflag %b resp %b want all 0",
                bus.dm_ena, bus.dm_wena, bus.dm_wflag, bus.resp_valid);
        end
        n_cmp++;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.resp_valid) pulses++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (bus.resp_valid) pulses++;
        end
        if (pulses !== 0 || bus.req_ready !== 1'b1) begin
            n_bad++; $display("FAIL rst_acc_after: resp pulses %0d ready %b want 0 1", pulses, bus.req_ready);
        end
        n_cmp++;
        issue(OP_LW, 32'h1001_0008, 32'h0, lat, rd, ex, code, bad, se, sw, sr, wf, wdata);
        model(OP_LW, 32'h1001_0008, 32'h0, mex, mcode, mbad, mrd, mwf);
        if (rd !== mrd || lat !== 2) begin
            n_bad++; $display("FAIL rst_acc_mem: rdata %h lat %0d want %h 2", rd, lat, mrd);
        end
        n_cmp++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3] = '{32'h1001_0010, 32'h1001_0014, 32'h1001_0010};
        logic [31:0] datas [3] = '{32'h0101_0101, 32'h0202_0202, 32'h0303_0303};
        int acc [3];
        int k, nresp, rdy_bad;
        logic rdy;
        int lat; logic [31:0] rd, bad, wdata; logic ex, se, sw, sr; logic [4:0] code; logic [3:0] wf;
        logic mex; logic [4:0] mcode; logic [31:0] mbad, mrd; logic [3:0] mwf;
        k = 0; nresp = 0; rdy_bad = 0;
        acc = '{-1, -1, -1};
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = OP_SW; bus.req_addr = addrs[0]; bus.req_wdata = datas[0];
        for (int c = 0; c < 14; c++) begin
            rdy = bus.req_ready;
            @(posedge clk);
            if (rdy && bus.req_valid && k < 3) begin
                acc[k] = c;
                model(OP_SW, addrs[k], datas[k], mex, mcode, mbad, mrd, mwf);
                k++;
            end
            @(negedge clk);
            if (bus.resp_valid) nresp++;
            if ((bus.dm_ena || bus.resp_valid) && bus.req_ready) rdy_bad++;
            if (k < 3) begin
                bus.req_addr = addrs[k]; bus.req_wdata = datas[k];
            end else begin
                bus.req_valid = 1'b0;
            end
        end
        if (acc[1] - acc[0] !== 3 || acc[2] - acc[1] !== 3) begin
            n_bad++; $display("FAIL b2b_spacing: accepts at %0d %0d %0d want spacing 3", acc[0], acc[1], acc[2]);
        end
        n_cmp++;
        if (nresp !== 3 || rdy_bad !== 0) begin
            n_bad++; $display("FAIL b2b_resp: pulses %0d busy-ready %0d want 3 0", nresp, rdy_bad);
        end
        n_cmp++;
        for (int i = 0; i < 2; i++) begin
            issue(OP_LW, addrs[i], 32'h0, lat, rd, ex, code, bad, se, sw, sr, wf, wdata);
            model(OP_LW, addrs[i], 32'h0, mex, mcode, mbad, mrd, mwf);
            if (rd !== mrd) begin
                n_bad++; $display("FAIL b2b_order[%0d]: got %h want %h", i, rd, mrd);
            end
            n_cmp++;
        end
    endtask

    task automatic test_random();
        logic [31:0] bnd [8];
        logic [3:0] op; logic [31:0] addr, rt;
        int lat; logic [31:0] rd, bad, wdata; logic ex, se, sw, sr; logic [4:0] code; logic [3:0] wf;
        logic mex; logic [4:0] mcode; logic [31:0] mbad, mrd; logic [3:0] mwf;
        bnd = '{BASE, BASE + 32'd1, BASE + MB - 32'd4, BASE + MB - 32'd2,
                BASE + MB - 32'd1, BASE + MB, BASE - 32'd1, BASE - 32'd4};
        for (int i = 0; i < 120; i++) begin
            op = ($urandom_range(0, 15) < 14) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(8, 15));
            addr = ($urandom_range(0, 3) == 0) ? bnd[$urandom_range(0, 7)]
                                               : BASE + 32'($urandom_range(0, 63));
            rt = $urandom;
            issue(op, addr, rt, lat, rd, ex, code, bad, se, sw, sr, wf, wdata);
            model(op, addr, rt, mex, mcode, mbad, mrd, mwf);
            if (lat !== (mex ? 1 : 2) || ex !== mex || se !== !mex) begin
                n_bad++; $display("FAIL rnd_flow[%0d] op %0d addr %h: lat %0d exc %b ena %b want %0d %b %b",
                    i, op, addr, lat, ex, se, mex ? 1 : 2, mex, !mex);
            end
            n_cmp++;
            if (rd !== mrd || (mex && (code !== mcode || bad !== mbad))) begin
                n_bad++; $display("FAIL rnd_data[%0d] op %0d addr %h: rdata %h code %0d bad %h want %h %0d %h",
                    i, op, addr, rd, code, bad, mrd, mcode, mbad);
            end
            n_cmp++;
            if (!mex && op_is_store(op)) begin
                if (wf !== mwf) begin
                    n_bad++; $display("FAIL rnd_wflag[%0d] addr %h: got %b want %b", i, addr, wf, mwf);
                end
                n_cmp++;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_addr = '0; bus.req_wdata = '0;
        for (int i = 0; i < int'(MB); i++) ref_mem[i] = 8'($urandom);
        for (int w = 0; w < int'(MB / 4); w++)
            dmem[w] = {ref_mem[4*w + 3], ref_mem[4*w + 2], ref_mem[4*w + 1], ref_mem[4*w]};
        test_reset();
        test_store_load();
        test_exceptions();
        test_reset_in_access();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
Load/store unit between the execute stage and the byte-lane data memory. It accepts one memory request at a time over a valid/ready handshake and checks alignment, range and opcode. It drives the data memory's enable, write-enable, byte write-flag, address and data. For loads it extracts and sign/zero-extends the addressed lane, and it returns a result or an address-error exception to the writeback/CP0 logic.

Parameters:
BASE_ADDR, 32'h1001_0000, first MIPS byte address mapped to data memory
MEM_BYTES, 1024, mapped size in bytes; valid range is BASE_ADDR to BASE_ADDR+MEM_BYTES-1

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  LSU can accept; high only in IDLE
req_op  in  4  memory op code (package encoding)
req_addr  in  32  MIPS virtual byte address (base + offset already summed)
req_wdata  in  32  store source register (rt)
resp_valid  out  1  one-cycle pulse: request finished
resp_rdata  out  32  extended load result; 0 for stores and exceptions
resp_exc  out  1  request raised an exception; qualifies resp_exc_code and resp_badvaddr
resp_exc_code  out  5  4=AdEL, 5=AdES, 10=RI (illegal op)
resp_badvaddr  out  32  faulting address
dm_ena  out  1  data memory enable
dm_wena  out  1  data memory write enable
dm_rena  out  1  data memory read enable
dm_wflag  out  4  byte write enables, bit i = byte lane i
dm_addr  out  32  word-aligned MIPS address {addr[31:2],2'b00}
dm_wdata  out  32  lane-replicated store data
dm_rdata  in  32  combinational read data from memory

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid, latch op, addr and wdata, then classify the request:
  - any exception -> RESP;
  - otherwise -> ACCESS.
- ACCESS (exactly 1 cycle):
  - Drives dm_ena=1.
  - Store: dm_wena=1, dm_rena=0; memory commits at the closing posedge.
  - Load: dm_rena=1, dm_wena=0; the extended lane is captured into the result register at the closing posedge.
  - Always -> RESP.
- RESP (exactly 1 cycle): resp_valid=1 with registered results, then -> IDLE. req_ready=0 in RESP, so there is no back-to-back accept.
- Latency from accept edge to resp_valid is 2 cycles for a legal access and 1 cycle for an exception. Throughput is one request per 3 cycles.
- Outside ACCESS, dm_ena, dm_wena, dm_rena and dm_wflag are all 0. dm_addr and dm_wdata hold their latched values, which are don't-care.
- Store lanes, with a = addr[1:0]:
  - SB: wflag = 4'b0001<<a, wdata = {4{rt[7:0]}}.
  - SH: wflag = a[1] ? 4'b1100 : 4'b0011, wdata = {2{rt[15:0]}}.
  - SW: wflag = 4'b1111, wdata = rt.
- Loads:
  - LB/LBU: select byte a of dm_rdata; sign-extend for LB, zero-extend for LBU.
  - LH/LHU: select half a[1]; sign-extend for LH, zero-extend for LHU.
  - LW: whole word.
- Exception priority:
  1. Illegal op -> RI.
  2. Misalignment (LH/LHU/SH with a[0]=1; LW/SW with a!=0) -> AdEL for loads, AdES for stores.
  3. Address outside the mapped range, including a word whose last byte falls outside -> AdEL/AdES.
- For RI, resp_badvaddr = addr. Memory is never touched on any exception.
- Reset, asserted asynchronously in any state:
  - State -> IDLE.
  - All resp_* and dm_* outputs -> 0.
  - req_ready -> 1 after deassertion.
  - A store in ACCESS when reset asserts is dropped: dm_ena falls immediately.
- req_valid is sampled only in IDLE. Inputs changing in ACCESS or RESP have no effect.

Decomposition:
- Package lsu_pkg: op encoding LB=0, LBU=1, LH=2, LHU=3, LW=4, SB=5, SH=6, SW=7 (8-15 illegal); exception codes EXC_ADEL=5'd4, EXC_ADES=5'd5, EXC_RI=5'd10; FSM state enum.
- One combinational sub-module, lsu_lane_align: given op, a, rt and dm_rdata, produce wflag, wdata and the extended load value.
- The FSM, request latch and range check stay in dmem_lsu.

Test Plan:
- After reset: SW addr=0x10010004 rt=0xDEADBEEF. Expect dm_wflag=4'b1111 in ACCESS, resp_valid 2 cycles after accept. Then LW 0x10010004 -> resp_rdata=0xDEADBEEF.
- With 0x10010004 holding 0xDEADBEEF:
  - LB 0x10010007 -> 0xFFFFFFDE.
  - LBU 0x10010007 -> 0x000000DE.
  - LH 0x10010006 -> 0xFFFFDEAD.
  - LHU 0x10010004 -> 0x0000BEEF.
- SB 0x10010005 rt=0x12345678: dm_wflag=4'b0010, dm_wdata=0x78787878. Then LW 0x10010004 -> 0xDEAD78EF.
- LW 0x10010006 -> resp_exc=1, code 4, badvaddr 0x10010006, after 1 cycle, dm_ena never high. SH 0x10010401 -> code 5. SW 0x10010400 -> code 5 (out of range). Op 4'hF -> code 10.
- Assert rst_n low during ACCESS of SW 0x10010008 rt=0x11111111. Expect dm_ena=0 immediately and no resp_valid. After release, LW 0x10010008 returns the prior contents, and req_ready=1.
- Hold req_valid high continuously with 3 SW requests. Exactly one accept per 3 cycles; req_ready=0 in ACCESS and RESP; 3 resp_valid pulses in order.
